// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage.
// - Drives a req/ack data-memory bus from the EX/MEM register contents.
// - Resolves the branch decision (PCSrc) and stalls the upstream pipeline
//   while a transfer is outstanding.
// - Registers its results into the MEM/WB boundary registers.
// - A transfer that waits TIMEOUT_CYCLES cycles without ack sets a sticky
//   bus error. The error is cleared only by rst.
// Optional feature macro: MEM_MISALIGN_CHECK_EN
//   When defined, a memory op whose address is not word aligned is
//   suppressed and reported through a one-cycle misalign_err pulse.
//   When undefined, addresses pass through unchecked and misalign_err is 0.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemWrite_in,
  input  logic        MemRead_in,
  input  logic        Branch_in,
  input  logic        Zero_in,
  input  logic [31:0] ALU_in,
  input  logic [31:0] WD_in,
  input  logic [4:0]  WN_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        PCSrc,
  output logic        bus_err,
  output logic        misalign_err,
  output logic        RegWrite_wb,
  output logic        MemtoReg_wb,
  output logic [31:0] RD_wb,
  output logic [31:0] ALU_wb,
  output logic [4:0]  WN_wb
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  // The timeout limit is compared in the counter's own width.
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             mem_op_s;
  logic             misalign_s;
  logic             in_err_s;
  logic             rd_capture_s;

  // Bus request, pass-through signals, stall and branch decision.
  always_comb begin
    mem_op_s = (MemRead_in | MemWrite_in) & ~bus_err;
`ifdef MEM_MISALIGN_CHECK_EN
    misalign_s = mem_op_s & (ALU_in[1:0] != 2'b00);
`else
    misalign_s = 1'b0;
`endif
    in_err_s   = (state_r == ST_ERR);
    dmem_req   = mem_op_s & ~in_err_s & ~misalign_s;
    // MemWrite wins when both read and write are set.
    dmem_we    = MemWrite_in;
    dmem_addr  = ALU_in;
    dmem_wdata = WD_in;
    stall      = dmem_req & ~dmem_ack;
    PCSrc      = Branch_in & Zero_in;
    cnt_inc_s  = cnt_r + CNT_ONE;
    // Read data is only meaningful for a granted read transfer.
    rd_capture_s = MemRead_in & dmem_req & dmem_ack & ~MemWrite_in;
  end

  // Wait-state FSM: counts stalled cycles and latches the sticky bus error.
  // The request cycle counts as the first waiting cycle, so a transfer may
  // stall for at most TIMEOUT_CYCLES cycles. An ack on the last allowed
  // cycle is a success.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_W'(0);
      bus_err <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (dmem_req & ~dmem_ack) begin
            if (CNT_ONE >= TIMEOUT_LIM) begin
              state_r <= ST_ERR;
              cnt_r   <= CNT_W'(0);
              bus_err <= 1'b1;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= CNT_ONE;
            end
          end else begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_W'(0);
          end
        end
        ST_WAIT: begin
          if (dmem_ack | ~dmem_req) begin
            // Completed, or the request was withdrawn.
            state_r <= ST_IDLE;
            cnt_r   <= CNT_W'(0);
          end else if (cnt_inc_s >= TIMEOUT_LIM) begin
            state_r <= ST_ERR;
            cnt_r   <= CNT_W'(0);
            bus_err <= 1'b1;
          end else begin
            cnt_r   <= cnt_inc_s;
          end
        end
        ST_ERR: begin
          state_r <= ST_ERR;
          bus_err <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_W'(0);
        end
      endcase
    end
  end

  // MEM/WB boundary registers: a stall inserts a bubble, otherwise capture.
  // Ops executed in the error state or suppressed as misaligned never write
  // back.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite_wb <= 1'b0;
      MemtoReg_wb <= 1'b0;
      RD_wb       <= 32'h0000_0000;
      ALU_wb      <= 32'h0000_0000;
      WN_wb       <= 5'd0;
    end else if (stall) begin
      RegWrite_wb <= 1'b0;
      MemtoReg_wb <= 1'b0;
    end else begin
      RegWrite_wb <= RegWrite_in & ~in_err_s & ~misalign_s;
      MemtoReg_wb <= MemtoReg_in;
      ALU_wb      <= ALU_in;
      WN_wb       <= WN_in;
      if (rd_capture_s) begin
        RD_wb <= dmem_rdata;
      end else begin
        RD_wb <= RD_wb;
      end
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_r;

  // One-cycle misalignment pulse, aligned with the MEM/WB registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= misalign_s;
    end
  end

  assign misalign_err = misalign_r;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT_CYCLES = 4).
// Honours MEM_MISALIGN_CHECK_EN the same way as the design.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        RegWrite_in, MemtoReg_in, MemWrite_in, MemRead_in;
  logic        Branch_in, Zero_in;
  logic [31:0] ALU_in, WD_in;
  logic [4:0]  WN_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, PCSrc, bus_err, misalign_err;
  logic        RegWrite_wb, MemtoReg_wb;
  logic [31:0] RD_wb, ALU_wb;
  logic [4:0]  WN_wb;

  int total_cnt = 0;
  int bad_cnt   = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .Branch_in(Branch_in), .Zero_in(Zero_in),
    .ALU_in(ALU_in), .WD_in(WD_in), .WN_in(WN_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .PCSrc(PCSrc), .bus_err(bus_err),
    .misalign_err(misalign_err),
    .RegWrite_wb(RegWrite_wb), .MemtoReg_wb(MemtoReg_wb),
    .RD_wb(RD_wb), .ALU_wb(ALU_wb), .WN_wb(WN_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever wedges.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rw, input logic m2r, input logic mw,
                        input logic mr, input logic br, input logic z,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] wn);
    RegWrite_in = rw; MemtoReg_in = m2r; MemWrite_in = mw; MemRead_in = mr;
    Branch_in = br; Zero_in = z; ALU_in = alu; WD_in = wd; WN_in = wn;
    #1;
  endtask

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check_val("rst_regwrite", {31'd0, RegWrite_wb}, 32'd0);
    check_val("rst_rd", RD_wb, 32'h0);
    check_val("rst_buserr", {31'd0, bus_err}, 32'd0);
    check_val("rst_stall", {31'd0, stall}, 32'd0);

    // Load left waiting until cnt=3, then reset for two cycles.
    set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 5'd3);
    tick(); tick(); tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_val("rr_wn", {27'd0, WN_wb}, 32'd0);
    check_val("rr_buserr", {31'd0, bus_err}, 32'd0);
    check_val("rr_req", {31'd0, dmem_req}, 32'd1);
    check_val("rr_stall", {31'd0, stall}, 32'd1);
    // Three more waiting cycles: bubbles, MEM/WB holds.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rr_bubble_rw", {31'd0, RegWrite_wb}, 32'd0);
      check_val("rr_hold_alu", ALU_wb, 32'h0);
      check_val("rr_wait_stall", {31'd0, stall}, 32'd1);
    end
    // Ack on the 4th (last allowed) waiting cycle is a success.
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    #1;
    check_val("lim_stall", {31'd0, stall}, 32'd0);
    tick();
    check_val("lim_rd", RD_wb, 32'hCAFE_F00D);
    check_val("lim_rw", {31'd0, RegWrite_wb}, 32'd1);
    check_val("lim_wn", {27'd0, WN_wb}, 32'd3);
    check_val("lim_alu", ALU_wb, 32'h40);
    check_val("lim_buserr", {31'd0, bus_err}, 32'd0);

    // Zero-wait load.
    dmem_rdata = 32'hDEAD_BEEF;
    set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 5'd5);
    check_val("ld_stall", {31'd0, stall}, 32'd0);
    check_val("ld_req", {31'd0, dmem_req}, 32'd1);
    check_val("ld_we", {31'd0, dmem_we}, 32'd0);
    check_val("ld_addr", dmem_addr, 32'h100);
    tick();
    check_val("ld_rd", RD_wb, 32'hDEAD_BEEF);
    check_val("ld_wn", {27'd0, WN_wb}, 32'd5);
    check_val("ld_rw", {31'd0, RegWrite_wb}, 32'd1);
    check_val("ld_m2r", {31'd0, MemtoReg_wb}, 32'd1);

    // Store with ack after 3 waiting cycles.
    dmem_ack = 1'b0; dmem_rdata = 32'h5555_AAAA;
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h1234_5678, 5'd7);
    for (int i = 0; i < 3; i++) begin
      check_val("st_stall", {31'd0, stall}, 32'd1);
      check_val("st_we", {31'd0, dmem_we}, 32'd1);
      check_val("st_wdata", dmem_wdata, 32'h1234_5678);
      check_val("st_addr", dmem_addr, 32'h200);
      tick();
      check_val("st_bubble_rw", {31'd0, RegWrite_wb}, 32'd0);
      check_val("st_hold_alu", ALU_wb, 32'h100);
    end
    dmem_ack = 1'b1;
    #1;
    check_val("st_ack_stall", {31'd0, stall}, 32'd0);
    tick();
    check_val("st_alu", ALU_wb, 32'h200);
    check_val("st_wn", {27'd0, WN_wb}, 32'd7);
    check_val("st_rd_hold", RD_wb, 32'hDEAD_BEEF);
    dmem_ack = 1'b0;

    // Branch decision on a non-memory op.
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55, 32'h0, 5'd9);
    check_val("br_taken", {31'd0, PCSrc}, 32'd1);
    check_val("br_req", {31'd0, dmem_req}, 32'd0);
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 32'h0, 5'd9);
    check_val("br_not", {31'd0, PCSrc}, 32'd0);
    tick();
    check_val("alu_rw", {31'd0, RegWrite_wb}, 32'd1);
    check_val("alu_val", ALU_wb, 32'h55);

    // Misaligned load.
    set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 5'd4);
`ifdef MEM_MISALIGN_CHECK_EN
    check_val("mis_req", {31'd0, dmem_req}, 32'd0);
    check_val("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    check_val("mis_pulse", {31'd0, misalign_err}, 32'd1);
    check_val("mis_rw", {31'd0, RegWrite_wb}, 32'd0);
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 5'd2);
    tick();
    check_val("mis_pulse_end", {31'd0, misalign_err}, 32'd0);
`else
    check_val("mis_req", {31'd0, dmem_req}, 32'd1);
    check_val("mis_addr", dmem_addr, 32'h102);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
    tick();
    check_val("mis_err", {31'd0, misalign_err}, 32'd0);
    check_val("mis_rw", {31'd0, RegWrite_wb}, 32'd1);
    check_val("mis_rd", RD_wb, 32'h1111_1111);
    dmem_ack = 1'b0;
`endif

    // Load that never gets an ack: 4 stall cycles, then sticky bus error.
    set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 5'd6);
    for (int i = 0; i < 4; i++) begin
      check_val("to_stall", {31'd0, stall}, 32'd1);
      tick();
      check_val("to_bubble_rw", {31'd0, RegWrite_wb}, 32'd0);
    end
    check_val("to_stall_end", {31'd0, stall}, 32'd0);
    check_val("to_buserr", {31'd0, bus_err}, 32'd1);
    check_val("to_req_off", {31'd0, dmem_req}, 32'd0);
    tick();
    check_val("to_err_rw", {31'd0, RegWrite_wb}, 32'd0);
    check_val("to_sticky", {31'd0, bus_err}, 32'd1);
    set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h304, 32'h0, 5'd8);
    check_val("to_next_req", {31'd0, dmem_req}, 32'd0);
    tick();
    check_val("to_next_rw", {31'd0, RegWrite_wb}, 32'd0);
    check_val("to_still_err", {31'd0, bus_err}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_val("to_rst_clr", {31'd0, bus_err}, 32'd0);
    check_val("to_rst_req", {31'd0, dmem_req}, 32'd1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
